// File: rtl/conv_intlv_pkg.sv
// Shared constants and helpers for the I=12, M=17 convolutional (Forney)
// byte interleaver / deinterleaver pair.
//   I            number of branches (commutator positions)
//   M            delay unit in bytes per branch step
//   W            data width in bits
//   TOTAL_DEPTH  words of shared branch storage, M*I*(I-1)/2
//   PRIME_COUNT  end-to-end delay in byte slots, I*(I-1)*M
package conv_intlv_pkg;

    localparam int unsigned I = 12;
    localparam int unsigned M = 17;
    localparam int unsigned W = 8;

    localparam int unsigned TOTAL_DEPTH = M * I * (I - 1) / 2;
    localparam int unsigned PRIME_COUNT = I * (I - 1) * M;

    localparam int unsigned BR_W   = $clog2(I);
    localparam int unsigned PTR_W  = $clog2((I - 1) * M);
    localparam int unsigned ADDR_W = $clog2(TOTAL_DEPTH);
    localparam int unsigned CNT_W  = $clog2(PRIME_COUNT + 1);

    typedef logic [BR_W-1:0]   br_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Deinterleaver branch j delays by (I-1-j)*M branch-bytes.
    function automatic int unsigned branch_depth(input int unsigned j);
        return (I - 1 - j) * M;
    endfunction

    // Branches are packed back to back in the shared RAM, branch 0 first.
    function automatic int unsigned branch_base(input int unsigned j);
        int unsigned b;
        b = 0;
        for (int unsigned k = 0; k < j; k++) begin
            b += branch_depth(k);
        end
        return b;
    endfunction

endpackage

// File: rtl/deint_ram.sv
// Single-port synchronous RAM holding all deinterleaver branch stores.
// Read-before-write: on an enabled cycle rdata takes the old word at addr
// while wdata is written to the same location. rdata holds otherwise.
//   clk    rising-edge clock
//   we     access enable (read old word and write new word)
//   addr   shared read/write address
//   wdata  word to write
//   rdata  registered old word
module deint_ram
    import conv_intlv_pkg::*;
(
    input  logic         clk,
    input  logic         we,
    input  addr_t        addr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [TOTAL_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_deinterleaver.sv
// Convolutional (Forney) byte deinterleaver, receive-side inverse of the
// I=12, M=17 interleaver. Branch j delays by (I-1-j)*M branch-bytes using
// circular pointers into one shared RAM; branch I-1 is a straight bypass.
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   in_valid    input byte strobe (no backpressure)
//   in_data     input byte
//   in_sync     packet-start marker, forces the byte onto branch 0
//   out_valid   output strobe, one cycle after the accepted input
//   out_data    deinterleaved byte
//   out_primed  high once every branch store has been fully written
//   sync_err    one-cycle pulse: in_sync arrived off branch 0
module conv_deinterleaver
    import conv_intlv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_sync,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_primed,
    output logic         sync_err
);

    br_t          br;
    br_t          br_cur;
    logic         bypass;
    logic         ram_en;
    addr_t        addr;
    addr_t        cand [I-1];
    logic [W-1:0] ram_q;
    logic [W-1:0] byp_q;
    logic         sel_byp;
    cnt_t         cnt;

    // A sync byte is taken as branch 0 regardless of the commutator.
    always_comb begin
        br_cur = (in_valid && in_sync) ? '0 : br;
        bypass = (br_cur == br_t'(I - 1));
        ram_en = in_valid && !bypass;
        addr   = '0;
        for (int unsigned j = 0; j < I - 1; j++) begin
            if (br_cur == br_t'(j)) begin
                addr = cand[j];
            end
        end
    end

    for (genvar g = 0; g < I - 1; g++) begin : g_branch
        localparam addr_t BASE = ADDR_W'(branch_base(g));
        localparam ptr_t  LAST = PTR_W'(branch_depth(g) - 1);
        ptr_t ptr;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ptr <= '0;
            end else if (in_valid && br_cur == br_t'(g)) begin
                ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
            end
        end

        assign cand[g] = BASE + ADDR_W'(ptr);
    end

    deint_ram u_ram (
        .clk   (clk),
        .we    (ram_en),
        .addr  (addr),
        .wdata (in_data),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br         <= '0;
            out_valid  <= 1'b0;
            sync_err   <= 1'b0;
            sel_byp    <= 1'b1;
            byp_q      <= '0;
            cnt        <= '0;
            out_primed <= 1'b0;
        end else begin
            out_valid <= in_valid;
            sync_err  <= in_valid && in_sync && (br != '0);
            if (in_valid) begin
                br      <= bypass ? '0 : br_cur + br_t'(1);
                sel_byp <= bypass;
                if (bypass) begin
                    byp_q <= in_data;
                end
                if (cnt != CNT_W'(PRIME_COUNT)) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (cnt == CNT_W'(PRIME_COUNT - 1)) begin
                    out_primed <= 1'b1;
                end
            end
        end
    end

    // out_data is a select between two registers: the RAM's read register
    // and the bypass register. Reset selects the cleared bypass register so
    // out_data reads 0 without resetting the RAM output; both registers and
    // the select only change on accepted bytes, so out_data holds on idles.
    assign out_data = sel_byp ? byp_q : ram_q;

endmodule
